// File: rtl/subleq_ctrl_pkg.sv
// Shared constants and state encoding for the SUBLEQ fetch/execute sequencer.
package subleq_ctrl_pkg;

   localparam int SUBLEQ_WORD_SIZE = 16;

   typedef enum logic [2:0] {
      CTRL_IDLE    = 3'd0,
      CTRL_FETCH_A = 3'd1,
      CTRL_FETCH_B = 3'd2,
      CTRL_FETCH_C = 3'd3,
      CTRL_READ_A  = 3'd4,
      CTRL_READ_B  = 3'd5,
      CTRL_WRITE_B = 3'd6,
      CTRL_HALT    = 3'd7
   } ctrl_state_e;

   // States in which a memory read request is outstanding.
   function automatic logic is_read_state(input ctrl_state_e s);
      logic rd_s;
      case (s)
         CTRL_FETCH_A, CTRL_FETCH_B, CTRL_FETCH_C,
         CTRL_READ_A, CTRL_READ_B: rd_s = 1'b1;
         default:                  rd_s = 1'b0;
      endcase
      return rd_s;
   endfunction

endpackage

// File: rtl/subleq_alu.sv
// SUBLEQ arithmetic: diff = b - a (modulo 2^WORD_SIZE) and the branch condition diff <= 0.
module subleq_alu
   import subleq_ctrl_pkg::*;
#(
   parameter int WORD_SIZE = SUBLEQ_WORD_SIZE
) (
   input  logic [WORD_SIZE-1:0] a,
   input  logic [WORD_SIZE-1:0] b,
   output logic [WORD_SIZE-1:0] diff,
   output logic                 leq
);

   assign diff = b - a;
   assign leq  = diff[WORD_SIZE-1] | (diff == {WORD_SIZE{1'b0}});

endmodule

// File: rtl/subleq_ctrl.sv
// SUBLEQ fetch/execute sequencer: walks A, B, C through the shared memory port,
// writes mem[B] - mem[A] back and steers the PC stage (inc, branch, halt).
module subleq_ctrl
   import subleq_ctrl_pkg::*;
#(
   parameter int                   WORD_SIZE = SUBLEQ_WORD_SIZE,
   parameter logic [WORD_SIZE-1:0] HALT_ADDR = {WORD_SIZE{1'b1}}
) (
   input  logic                 clk,
   input  logic                 areset_n,
   input  logic                 run,
   input  logic [WORD_SIZE-1:0] pc_in,
   output logic                 pc_inc,
   output logic                 pc_branch,
   output logic [WORD_SIZE-1:0] pc_addr,
   output logic [WORD_SIZE-1:0] mem_addr,
   output logic                 mem_rd,
   output logic                 mem_wr,
   output logic [WORD_SIZE-1:0] mem_wdata,
   input  logic [WORD_SIZE-1:0] mem_rdata,
   input  logic                 mem_ack,
   output logic                 instr_done,
   output logic                 halted
);

   ctrl_state_e          state_r;
   ctrl_state_e          next_state_s;
   logic [WORD_SIZE-1:0] op_a_r;
   logic [WORD_SIZE-1:0] op_b_r;
   logic [WORD_SIZE-1:0] op_c_r;
   logic [WORD_SIZE-1:0] val_a_r;
   logic [WORD_SIZE-1:0] val_b_r;
   logic [WORD_SIZE-1:0] diff_s;
   logic                 leq_s;
   logic                 pc_inc_s;
   logic                 pc_branch_s;
   logic                 instr_done_s;
   logic                 mem_rd_r;
   logic                 mem_wr_r;
   logic                 halted_r;
   logic [WORD_SIZE-1:0] mem_addr_s;

   subleq_alu #(
      .WORD_SIZE (WORD_SIZE)
   ) u_alu (
      .a    (val_a_r),
      .b    (val_b_r),
      .diff (diff_s),
      .leq  (leq_s)
   );

   // State register and registered request/halt flags derived from the next state.
   always_ff @(posedge clk) begin
      if (!areset_n) begin
         state_r  <= CTRL_IDLE;
         mem_rd_r <= 1'b0;
         mem_wr_r <= 1'b0;
         halted_r <= 1'b0;
      end else begin
         state_r  <= next_state_s;
         mem_rd_r <= is_read_state(next_state_s);
         mem_wr_r <= (next_state_s == CTRL_WRITE_B);
         halted_r <= (next_state_s == CTRL_HALT);
      end
   end

   // Next-state logic plus the single-cycle PC and retire pulses, all qualified by mem_ack.
   always_comb begin
      next_state_s = state_r;
      pc_inc_s     = 1'b0;
      pc_branch_s  = 1'b0;
      instr_done_s = 1'b0;
      case (state_r)
         CTRL_IDLE: begin
            if (run) begin
               next_state_s = CTRL_FETCH_A;
            end else begin
               next_state_s = CTRL_IDLE;
            end
         end
         CTRL_FETCH_A: begin
            if (mem_ack) begin
               pc_inc_s     = 1'b1;
               next_state_s = CTRL_FETCH_B;
            end else begin
               next_state_s = CTRL_FETCH_A;
            end
         end
         CTRL_FETCH_B: begin
            if (mem_ack) begin
               pc_inc_s     = 1'b1;
               next_state_s = CTRL_FETCH_C;
            end else begin
               next_state_s = CTRL_FETCH_B;
            end
         end
         CTRL_FETCH_C: begin
            if (mem_ack) begin
               pc_inc_s     = 1'b1;
               next_state_s = CTRL_READ_A;
            end else begin
               next_state_s = CTRL_FETCH_C;
            end
         end
         CTRL_READ_A: begin
            if (mem_ack) begin
               next_state_s = CTRL_READ_B;
            end else begin
               next_state_s = CTRL_READ_A;
            end
         end
         CTRL_READ_B: begin
            if (mem_ack) begin
               next_state_s = CTRL_WRITE_B;
            end else begin
               next_state_s = CTRL_READ_B;
            end
         end
         CTRL_WRITE_B: begin
            if (mem_ack) begin
               instr_done_s = 1'b1;
               if (leq_s && (op_c_r == HALT_ADDR)) begin
                  next_state_s = CTRL_HALT;
               end else if (leq_s) begin
                  pc_branch_s  = 1'b1;
                  next_state_s = CTRL_FETCH_A;
               end else begin
                  next_state_s = CTRL_FETCH_A;
               end
            end else begin
               next_state_s = CTRL_WRITE_B;
            end
         end
         CTRL_HALT: begin
            next_state_s = CTRL_HALT;
         end
         default: begin
            next_state_s = CTRL_IDLE;
         end
      endcase
   end

   // Operand and value capture on the acknowledged read of each step.
   always_ff @(posedge clk) begin
      if (!areset_n) begin
         op_a_r  <= {WORD_SIZE{1'b0}};
         op_b_r  <= {WORD_SIZE{1'b0}};
         op_c_r  <= {WORD_SIZE{1'b0}};
         val_a_r <= {WORD_SIZE{1'b0}};
         val_b_r <= {WORD_SIZE{1'b0}};
      end else if (mem_ack) begin
         case (state_r)
            CTRL_FETCH_A: op_a_r  <= mem_rdata;
            CTRL_FETCH_B: op_b_r  <= mem_rdata;
            CTRL_FETCH_C: op_c_r  <= mem_rdata;
            CTRL_READ_A:  val_a_r <= mem_rdata;
            CTRL_READ_B:  val_b_r <= mem_rdata;
            default:      op_a_r  <= op_a_r;
         endcase
      end else begin
         op_a_r <= op_a_r;
      end
   end

   // Address mux: fetches follow the PC stage, data accesses use latched operands.
   always_comb begin
      mem_addr_s = {WORD_SIZE{1'b0}};
      case (state_r)
         CTRL_FETCH_A, CTRL_FETCH_B, CTRL_FETCH_C: mem_addr_s = pc_in;
         CTRL_READ_A:                              mem_addr_s = op_a_r;
         CTRL_READ_B, CTRL_WRITE_B:                mem_addr_s = op_b_r;
         default:                                  mem_addr_s = {WORD_SIZE{1'b0}};
      endcase
   end

   // Pulses are masked while reset is asserted so an in-flight ack has no effect.
   assign pc_inc     = pc_inc_s & areset_n;
   assign pc_branch  = pc_branch_s & areset_n;
   assign instr_done = instr_done_s & areset_n;
   assign pc_addr    = op_c_r;
   assign mem_addr   = mem_addr_s;
   assign mem_rd     = mem_rd_r;
   assign mem_wr     = mem_wr_r;
   assign mem_wdata  = diff_s;
   assign halted     = halted_r;

endmodule
